// File: rtl/picobus_arb2.sv
// Two-requester round-robin arbiter/sequencer for the PicoBus register slaves.
// Optional grant/conflict counters are enabled with `define PICOBUS_ARB_STATS_EN.
module picobus_arb2 #(
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic        PicoClk,
  input  logic        PicoRst,
  input  logic        Req0,
  input  logic        Wr0,
  input  logic [31:0] Addr0,
  input  logic [31:0] WrData0,
  output logic        Gnt0,
  output logic        RdValid0,
  output logic [31:0] RdData0,
  input  logic        Req1,
  input  logic        Wr1,
  input  logic [31:0] Addr1,
  input  logic [31:0] WrData1,
  output logic        Gnt1,
  output logic        RdValid1,
  output logic [31:0] RdData1,
  output logic [31:0] PicoAddr,
  output logic [31:0] PicoDataIn,
  output logic        PicoRd,
  output logic        PicoWr,
`ifdef PICOBUS_ARB_STATS_EN
  output logic [15:0] GntCnt0,
  output logic [15:0] GntCnt1,
  output logic [15:0] ConflictCnt,
`endif
  input  logic [31:0] PicoDataOut
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

  localparam logic [1:0] CntInit = 2'(RD_LATENCY - 1);

  state_e     r_state;
  logic       r_owner;
  logic       r_last;
  logic [1:0] r_cnt;

  logic        w_win;
  logic        w_wr;
  logic [31:0] w_addr;
  logic [31:0] w_data;

  // On a tie the requester not granted last wins; r_last resets to 1 so requester 0 wins first.
  always_comb begin
    w_win = 1'b0;
    if (Req0 && Req1) begin
      w_win = ~r_last;
    end else begin
      w_win = Req1;
    end
    w_wr   = w_win ? Wr1 : Wr0;
    w_addr = w_win ? Addr1 : Addr0;
    w_data = w_win ? WrData1 : WrData0;
  end

  always_ff @(posedge PicoClk) begin
    if (PicoRst) begin
      r_state    <= StIdle;
      r_owner    <= 1'b0;
      r_last     <= 1'b1;
      r_cnt      <= 2'd0;
      Gnt0       <= 1'b0;
      Gnt1       <= 1'b0;
      RdValid0   <= 1'b0;
      RdValid1   <= 1'b0;
      RdData0    <= 32'h0;
      RdData1    <= 32'h0;
      PicoAddr   <= 32'h0;
      PicoDataIn <= 32'h0;
      PicoRd     <= 1'b0;
      PicoWr     <= 1'b0;
    end else begin
      Gnt0     <= 1'b0;
      Gnt1     <= 1'b0;
      PicoRd   <= 1'b0;
      PicoWr   <= 1'b0;
      RdValid0 <= 1'b0;
      RdValid1 <= 1'b0;
      case (r_state)
        StIdle: begin
          if (Req0 || Req1) begin
            r_owner    <= w_win;
            PicoAddr   <= w_addr;
            PicoDataIn <= w_data;
            PicoWr     <= w_wr;
            PicoRd     <= ~w_wr;
            Gnt0       <= ~w_win;
            Gnt1       <= w_win;
            r_state    <= StIssue;
          end
        end
        StIssue: begin
          r_last  <= r_owner;
          r_cnt   <= CntInit;
          r_state <= PicoWr ? StIdle : StWait;
        end
        StWait: begin
          if (r_cnt == 2'd0) begin
            if (r_owner) begin
              RdData1  <= PicoDataOut;
              RdValid1 <= 1'b1;
            end else begin
              RdData0  <= PicoDataOut;
              RdValid0 <= 1'b1;
            end
            r_state <= StDone;
          end else begin
            r_cnt <= r_cnt - 2'd1;
          end
        end
        StDone:  r_state <= StIdle;
        default: r_state <= StIdle;
      endcase
    end
  end

`ifdef PICOBUS_ARB_STATS_EN
  logic w_decide;
  assign w_decide = (r_state == StIdle) && (Req0 || Req1);

  always_ff @(posedge PicoClk) begin
    if (PicoRst) begin
      GntCnt0     <= 16'h0;
      GntCnt1     <= 16'h0;
      ConflictCnt <= 16'h0;
    end else begin
      if (w_decide && !w_win && (GntCnt0 != 16'hFFFF)) begin
        GntCnt0 <= GntCnt0 + 16'd1;
      end
      if (w_decide && w_win && (GntCnt1 != 16'hFFFF)) begin
        GntCnt1 <= GntCnt1 + 16'd1;
      end
      if (w_decide && Req0 && Req1 && (ConflictCnt != 16'hFFFF)) begin
        ConflictCnt <= ConflictCnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_picobus_arb2.sv
// Directed bench for picobus_arb2: one instance at RD_LATENCY=1, one at RD_LATENCY=4,
// both driven by the same stimulus.
module tb_picobus_arb2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, wr0, req1, wr1;
  logic [31:0] addr0, wdata0, addr1, wdata1, dout;

  logic        gnt0, gnt1, rv0, rv1, prd, pwr;
  logic [31:0] rd0, rd1, paddr, pdin;
  logic        gnt0_4, gnt1_4, rv0_4, rv1_4, prd_4, pwr_4;
  logic [31:0] rd0_4, rd1_4, paddr_4, pdin_4;
`ifdef PICOBUS_ARB_STATS_EN
  logic [15:0] gc0, gc1, cc, gc0_4, gc1_4, cc_4;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  picobus_arb2 #(.RD_LATENCY(1)) u_dut1 (
    .PicoClk(clk), .PicoRst(rst),
    .Req0(req0), .Wr0(wr0), .Addr0(addr0), .WrData0(wdata0),
    .Gnt0(gnt0), .RdValid0(rv0), .RdData0(rd0),
    .Req1(req1), .Wr1(wr1), .Addr1(addr1), .WrData1(wdata1),
    .Gnt1(gnt1), .RdValid1(rv1), .RdData1(rd1),
    .PicoAddr(paddr), .PicoDataIn(pdin), .PicoRd(prd), .PicoWr(pwr),
`ifdef PICOBUS_ARB_STATS_EN
    .GntCnt0(gc0), .GntCnt1(gc1), .ConflictCnt(cc),
`endif
    .PicoDataOut(dout)
  );

  picobus_arb2 #(.RD_LATENCY(4)) u_dut4 (
    .PicoClk(clk), .PicoRst(rst),
    .Req0(req0), .Wr0(wr0), .Addr0(addr0), .WrData0(wdata0),
    .Gnt0(gnt0_4), .RdValid0(rv0_4), .RdData0(rd0_4),
    .Req1(req1), .Wr1(wr1), .Addr1(addr1), .WrData1(wdata1),
    .Gnt1(gnt1_4), .RdValid1(rv1_4), .RdData1(rd1_4),
    .PicoAddr(paddr_4), .PicoDataIn(pdin_4), .PicoRd(prd_4), .PicoWr(pwr_4),
`ifdef PICOBUS_ARB_STATS_EN
    .GntCnt0(gc0_4), .GntCnt1(gc1_4), .ConflictCnt(cc_4),
`endif
    .PicoDataOut(dout)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    logic got;
    logic seen;
    rst = 1'b1; req0 = 1'b0; wr0 = 1'b0; req1 = 1'b0; wr1 = 1'b0;
    addr0 = '0; wdata0 = '0; addr1 = '0; wdata1 = '0; dout = '0;
    step(); step();
    rst = 1'b0;

    // Reset state
    chk("rst_ctl1", 32'({gnt0, gnt1, rv0, rv1, prd, pwr}), 32'h0);
    chk("rst_bus1", paddr | pdin | rd0 | rd1, 32'h0);
    chk("rst_ctl4", 32'({gnt0_4, gnt1_4, rv0_4, rv1_4, prd_4, pwr_4}), 32'h0);

    // Single write from requester 0
    req0 = 1'b1; wr0 = 1'b1; addr0 = 32'h10; wdata0 = 32'hDEADBEEF;
    step();
    chk("wr_strobe", 32'({pwr, prd}), 32'h2);
    chk("wr_addr", paddr, 32'h10);
    chk("wr_data", pdin, 32'hDEADBEEF);
    chk("wr_gnt", 32'({gnt0, gnt1}), 32'h2);
    req0 = 1'b0;
    step();
    chk("wr_after", 32'({pwr, prd, gnt0, gnt1}), 32'h0);
    chk("wr_addr_hold", paddr, 32'h10);
    step();

    // Single read from requester 1, RD_LATENCY=1
    req1 = 1'b1; wr1 = 1'b0; addr1 = 32'h10000; dout = 32'hFFFF0000;
    step();
    chk("rd1_issue", 32'({gnt1, gnt0, prd, pwr}), 32'hA);
    chk("rd1_addr", paddr, 32'h10000);
    req1 = 1'b0; dout = 32'h12345678;
    step();
    chk("rd1_wait", 32'({prd, rv1, rv0}), 32'h0);
    chk("rd1_wait_addr", paddr, 32'h10000);
    step();
    chk("rd1_valid", 32'({rv1, rv0}), 32'h2);
    chk("rd1_data", rd1, 32'h12345678);
    dout = 32'h0;
    step();
    chk("rd1_pulse", 32'(rv1), 32'h0);
    chk("rd1_hold", rd1, 32'h12345678);

    rst = 1'b1; step(); rst = 1'b0;

    // Both requesting reads continuously: grants alternate starting with 0
    req0 = 1'b1; req1 = 1'b1; wr0 = 1'b0; wr1 = 1'b0;
    addr0 = 32'h100; addr1 = 32'h200;
    for (int g = 0; g < 4; g++) begin
      got = 1'b0;
      for (int k = 0; k < 12 && !got; k++) begin
        step();
        if (gnt0 || gnt1) got = 1'b1;
      end
      chk("rr_seen", 32'(got), 32'h1);
      chk("rr_order", 32'({gnt1, gnt0}), (g % 2 == 1) ? 32'h2 : 32'h1);
      chk("rr_addr", paddr, (g % 2 == 1) ? 32'h200 : 32'h100);
    end
`ifdef PICOBUS_ARB_STATS_EN
    chk("stat_conflict", 32'(cc), 32'd4);
    chk("stat_gnt0", 32'(gc0), 32'd2);
    chk("stat_gnt1", 32'(gc1), 32'd2);
`endif
    req0 = 1'b0; req1 = 1'b0;
    for (int k = 0; k < 4; k++) step();
    rst = 1'b1; step(); rst = 1'b0;

    // RD_LATENCY=4: only the value in the 4th cycle after PicoRd is captured
    req0 = 1'b1; wr0 = 1'b0; addr0 = 32'h20;
    step();
    chk("rd4_issue", 32'({gnt0_4, prd_4, pwr_4}), 32'h6);
    req0 = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      step();
      dout = (k == 4) ? 32'hAABBCCDD : (32'h11110000 + 32'(k));
      chk("rd4_early", 32'(rv0_4), 32'h0);
      if (k == 2) begin
        chk("rd1_lat_valid", 32'(rv0), 32'h1);
        chk("rd1_lat_data", rd0, 32'h11110001);
      end
    end
    step();
    chk("rd4_valid", 32'(rv0_4), 32'h1);
    chk("rd4_data", rd0_4, 32'hAABBCCDD);
    dout = 32'h0;
    step();

    // Reset during WAIT drops the read
    req1 = 1'b1; wr1 = 1'b0; addr1 = 32'h30;
    step();
    req1 = 1'b0;
    step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_ctl", 32'({gnt0_4, gnt1_4, rv0_4, rv1_4, prd_4, pwr_4}), 32'h0);
    chk("mid_rst_bus", paddr_4 | pdin_4 | rd0_4 | rd1_4, 32'h0);
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (rv1_4 || rv1) seen = 1'b1;
    end
    chk("mid_rst_norv", 32'(seen), 32'h0);
    req1 = 1'b1; addr1 = 32'h40; dout = 32'h5A5A5A5A;
    step();
    chk("post_rst_issue", 32'({gnt1_4, prd_4}), 32'h3);
    req1 = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      step();
      if (rv1_4) got = 1'b1;
    end
    chk("post_rst_valid", 32'(got), 32'h1);
    chk("post_rst_data", rd1_4, 32'h5A5A5A5A);
    dout = 32'h0;
    step();

    // Req0 pulsed for one cycle during WAIT is withdrawn
    req1 = 1'b1; addr1 = 32'h50;
    step();
    req1 = 1'b0;
    step();
    req0 = 1'b1; wr0 = 1'b1; addr0 = 32'h60;
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      req0 = 1'b0;
      if (gnt0 || gnt0_4 || pwr || pwr_4 || prd || prd_4) seen = 1'b1;
    end
    chk("withdraw", 32'(seen), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
